// File: rtl/ahb_cfg_responder.sv
// AHB-Lite subordinate exposing static configuration words as a read-only window plus one scratch word.
// Optional two-cycle ERROR responses are compiled in when CFG_ERR_RESP_EN is defined.
module ahb_cfg_responder #(
  parameter int AHBW       = 64,
  parameter int ADDRW      = 8,
  parameter int NUMWORDS   = 16,
  parameter int WAITSTATES = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSELCfg,
  input  logic [ADDRW-1:0]         HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic                     HREADY,
  input  logic [AHBW-1:0]          HWDATA,
  input  logic [NUMWORDS*AHBW-1:0] CfgWords,
  output logic [AHBW-1:0]          HRDATACfg,
  output logic                     HREADYCfg,
  output logic                     HRESPCfg
);
  localparam int NBYTES = AHBW / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int IDXW   = ADDRW - OFFW;
  localparam int CNTW   = 4;
  localparam logic [IDXW-1:0] SCRATCH_IDX = IDXW'(NUMWORDS - 1);
  localparam logic [CNTW-1:0] WS_LAST     = CNTW'(WAITSTATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [ADDRW-1:0] addr_q;
  logic             write_q;
  logic [2:0]       size_q;
  logic             wr_pend_q;
  logic [OFFW-1:0]  wr_off_q;
  logic [2:0]       wr_size_q;
  logic [AHBW-1:0]  scratch_q;
  logic [AHBW-1:0]  rdata_q;
  logic             hready_q;
  logic             hresp_q;

  logic             accept_s;
  logic             cmp_s;
  logic             cmp_write_s;
  logic             cmp_err_s;
  logic [ADDRW-1:0] cmp_addr_s;
  logic [2:0]       cmp_size_s;
  logic [IDXW-1:0]  cmp_idx_s;
  logic [AHBW-1:0]  scratch_d;
  logic [AHBW-1:0]  cmp_rdata_s;
  logic             cfg_unused_s;

  function automatic logic [AHBW-1:0] merge_bytes(
    input logic [AHBW-1:0] old_word,
    input logic [AHBW-1:0] new_word,
    input logic [OFFW-1:0] off,
    input logic [2:0]      size
  );
    logic [AHBW-1:0] res;
    int              lo;
    int              hi;
    res = old_word;
    lo  = int'(off);
    hi  = lo + int'(32'd1 << size);
    for (int i = 0; i < NBYTES; i++) begin
      if ((i >= lo) && (i < hi)) begin
        res[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // The top configuration slot is shadowed by the scratch register; HTRANS[0] has no meaning here.
  assign cfg_unused_s = HTRANS[0] ^ (^CfgWords[(NUMWORDS-1)*AHBW +: AHBW]);

  // Pick the transfer whose data phase completes this cycle and pre-compute its response.
  always_comb begin
    accept_s    = HSELCfg && HREADY && HTRANS[1] &&
                  ((state_q == S_IDLE) || (state_q == S_ERR2));
    cmp_s       = 1'b0;
    cmp_addr_s  = addr_q;
    cmp_write_s = write_q;
    cmp_size_s  = size_q;
    if ((state_q == S_WAIT) && (cnt_q == WS_LAST)) begin
      cmp_s = 1'b1;
    end else if (accept_s && (WAITSTATES == 0)) begin
      cmp_s       = 1'b1;
      cmp_addr_s  = HADDR;
      cmp_write_s = HWRITE;
      cmp_size_s  = HSIZE;
    end else begin
      cmp_s = 1'b0;
    end
    cmp_idx_s = cmp_addr_s[ADDRW-1:OFFW];
`ifdef CFG_ERR_RESP_EN
    cmp_err_s = cmp_s && ((int'(cmp_idx_s) >= NUMWORDS) ||
                          (cmp_write_s && (cmp_idx_s != SCRATCH_IDX)));
`else
    cmp_err_s = 1'b0;
`endif
    // Forwarded so a read completing alongside the scratch commit sees the new value.
    if (wr_pend_q) begin
      scratch_d = merge_bytes(scratch_q, HWDATA, wr_off_q, wr_size_q);
    end else begin
      scratch_d = scratch_q;
    end
    cmp_rdata_s = '0;
    for (int i = 0; i < NUMWORDS - 1; i++) begin
      if (cmp_idx_s == IDXW'(i)) begin
        cmp_rdata_s = CfgWords[i*AHBW +: AHBW];
      end else begin
        cmp_rdata_s = cmp_rdata_s;
      end
    end
    if (cmp_idx_s == SCRATCH_IDX) begin
      cmp_rdata_s = scratch_d;
    end else begin
      cmp_rdata_s = cmp_rdata_s;
    end
  end

  // Response FSM, wait counter, captured address phase, scratch register and registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNTW{1'b0}};
      addr_q    <= {ADDRW{1'b0}};
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      wr_pend_q <= 1'b0;
      wr_off_q  <= {OFFW{1'b0}};
      wr_size_q <= 3'd0;
      scratch_q <= {AHBW{1'b0}};
      rdata_q   <= {AHBW{1'b0}};
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      wr_pend_q <= 1'b0;
      if (accept_s) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
      if (cmp_s) begin
        cnt_q <= {CNTW{1'b0}};
        if (cmp_err_s) begin
          state_q  <= S_ERR1;
          hready_q <= 1'b0;
          hresp_q  <= 1'b1;
        end else begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (cmp_write_s) begin
            wr_pend_q <= (cmp_idx_s == SCRATCH_IDX);
            wr_off_q  <= cmp_addr_s[OFFW-1:0];
            wr_size_q <= cmp_size_s;
          end else begin
            rdata_q <= cmp_rdata_s;
          end
        end
      end else if (accept_s) begin
        state_q  <= S_WAIT;
        cnt_q    <= {{(CNTW-1){1'b0}}, 1'b1};
        hready_q <= 1'b0;
        hresp_q  <= 1'b0;
      end else begin
        case (state_q)
          S_WAIT: begin
            cnt_q    <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            hready_q <= 1'b0;
            hresp_q  <= 1'b0;
          end
          S_ERR1: begin
            state_q  <= S_ERR2;
            hready_q <= 1'b1;
            hresp_q  <= 1'b1;
          end
          default: begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign HRDATACfg = rdata_q;
  assign HREADYCfg = hready_q;
  assign HRESPCfg  = hresp_q;

endmodule

// File: tb/tb_ahb_cfg_responder.sv
// Randomised bench for ahb_cfg_responder: two instances (zero and two wait states) each checked
// every cycle against a transaction-level model of the expected response timeline and data.
module tb_ahb_cfg_responder;
  bit clk;
  always #5 clk = ~clk;

  logic [16*64-1:0] cfg;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    bit          sel;
    logic [1:0]  tr;
    logic [7:0]  a;
    bit          wr;
    logic [2:0]  sz;
    logic [63:0] wd;
  } stim_t;

  typedef struct {
    bit          hready;
    bit          hresp;
    bit          done;
    bit          wr;
    logic [7:0]  a;
    logic [2:0]  sz;
  } exp_t;

  task automatic check(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t: got %h, want %h", nm, inst, $time, act, exp);
    end
  endtask

  function automatic stim_t mk(bit rst, bit sel, logic [1:0] tr, logic [7:0] a, bit wr,
                               logic [2:0] sz, logic [63:0] wd);
    stim_t s;
    s.rst = rst; s.sel = sel; s.tr = tr; s.a = a; s.wr = wr; s.sz = sz; s.wd = wd;
    return s;
  endfunction

  function automatic exp_t mk_exp(bit hr, bit hs, bit dn, bit wr, logic [7:0] a, logic [2:0] sz);
    exp_t e;
    e.hready = hr; e.hresp = hs; e.done = dn; e.wr = wr; e.a = a; e.sz = sz;
    return e;
  endfunction

  function automatic stim_t rnd_item();
    int sz;
    int w;
    int off;
    sz  = $urandom_range(0, 3);
    w   = ($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 19);
    off = $urandom_range(0, 7) & ~((1 << sz) - 1);
    return mk(1'b0, $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 8'(w * 8 + off),
              $urandom_range(0, 1) == 1, 3'(sz), {$urandom, $urandom});
  endfunction

  // Word visible at a byte address: config word, scratch, or zero beyond the window.
  function automatic logic [63:0] m_lookup(input logic [7:0] a, input logic [63:0] scr);
    int idx;
    idx = int'(a) / 8;
    if (idx == 15) return scr;
    else if (idx < 15) return cfg[idx*64 +: 64];
    else return 64'h0;
  endfunction

  // Little-endian lane write: 2**sz bytes starting at lane a%8.
  function automatic logic [63:0] m_merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] a, input logic [2:0] sz);
    logic [127:0] mask;
    mask = ((128'd1 << (8 * (1 << sz))) - 128'd1) << (8 * (a % 8));
    return (old & ~mask[63:0]) | (wd & mask[63:0]);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int WS = (g == 0) ? 0 : 2;
    logic        rst_n, sel, write;
    logic [1:0]  trans;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [63:0] hwdata;
    logic [63:0] rdata;
    logic        hready_o, hresp_o;
    logic [63:0] m_scr, m_rd;
    exp_t        exq[$];
    stim_t       sq[$];
    bit          done;

    ahb_cfg_responder #(.AHBW(64), .ADDRW(8), .NUMWORDS(16), .WAITSTATES(WS)) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .HSELCfg(sel), .HADDR(addr), .HTRANS(trans),
      .HWRITE(write), .HSIZE(size), .HREADY(hready_o), .HWDATA(hwdata), .CfgWords(cfg),
      .HRDATACfg(rdata), .HREADYCfg(hready_o), .HRESPCfg(hresp_o));

    always @(negedge clk) begin
      exp_t e;
      int   idx;
      bit   err;
      if (!rst_n) begin
        exq.delete();
        m_scr = 64'h0;
        m_rd  = 64'h0;
      end else begin
        e = (exq.size() > 0) ? exq.pop_front() : mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 3'd0);
        if (e.done && !e.wr) m_rd = m_lookup(e.a, m_scr);
        check("hready", g, {63'h0, hready_o}, {63'h0, e.hready});
        check("hresp", g, {63'h0, hresp_o}, {63'h0, e.hresp});
        check("rdata", g, rdata, m_rd);
        if (e.done && !e.wr && (e.a[7:3] == 5'd0))
          check("word0_lit", g, rdata, 64'h8000_0000_0014_112D);
        if (e.done && e.wr && (int'(e.a) / 8 == 15)) m_scr = m_merge(m_scr, hwdata, e.a, e.sz);
        if (sel && trans[1] && e.hready) begin
          idx = int'(addr) / 8;
`ifdef CFG_ERR_RESP_EN
          err = (idx >= 16) || (write && (idx != 15));
`else
          err = 1'b0;
`endif
          for (int k = 0; k < WS; k++) exq.push_back(mk_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 3'd0));
          if (err) begin
            exq.push_back(mk_exp(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 3'd0));
            exq.push_back(mk_exp(1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 3'd0));
          end else begin
            exq.push_back(mk_exp(1'b1, 1'b0, 1'b1, write, addr, size));
          end
        end
      end
    end

    initial begin
      stim_t cur;
      stim_t nx;
      bit    adv;
      rst_n = 1'b0; sel = 1'b0; trans = 2'b00; addr = 8'h0; write = 1'b0; size = 3'd0;
      hwdata = 64'h0;
      cur = mk(1'b0, 1'b0, 2'b00, 8'h0, 1'b0, 3'd0, 64'h0);
      sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 3'd3, 64'h0));
      sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h7A, 1'b1, 3'd0, 64'h0000_0000_00A5_0000));
      sq.push_back(mk(1'b0, 1'b1, 2'b11, 8'h78, 1'b0, 3'd3, 64'h0));
      sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h08, 1'b0, 3'd3, 64'h0));
      sq.push_back(mk(1'b0, 1'b1, 2'b11, 8'h10, 1'b0, 3'd3, 64'h0));
      sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h18, 1'b1, 3'd3, 64'hDEAD_BEEF_0BAD_F00D));
      sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h18, 1'b0, 3'd3, 64'h0));
      sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h80, 1'b0, 3'd3, 64'h0));
      sq.push_back(mk(1'b0, 1'b1, 2'b00, 8'h78, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF));
      sq.push_back(mk(1'b0, 1'b1, 2'b01, 8'h78, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF));
      sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h78, 1'b0, 3'd3, 64'h0));
      if (WS != 0) begin
        sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h08, 1'b0, 3'd3, 64'h0));
        sq.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 3'd0, 64'h0));
        sq.push_back(mk(1'b0, 1'b1, 2'b10, 8'h78, 1'b0, 3'd3, 64'h0));
      end
      for (int i = 0; i < 300; i++) sq.push_back(rnd_item());
      repeat (3) @(posedge clk);
      #2;
      check("rst_hready", g, {63'h0, hready_o}, 64'h1);
      check("rst_hresp", g, {63'h0, hresp_o}, 64'h0);
      check("rst_rdata", g, rdata, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      while (sq.size() > 0) begin
        @(negedge clk);
        adv = hready_o;
        @(posedge clk);
        #1;
        if (adv) begin
          hwdata = cur.wr ? cur.wd : {$urandom, $urandom};
          nx = sq.pop_front();
          if (nx.rst) begin
            // Reset lands while the previous read is sitting in its wait states.
            #2 rst_n = 1'b0;
            #1;
            check("arst_hready", g, {63'h0, hready_o}, 64'h1);
            check("arst_hresp", g, {63'h0, hresp_o}, 64'h0);
            check("arst_rdata", g, rdata, 64'h0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            cur = mk(1'b0, 1'b0, 2'b00, 8'h0, 1'b0, 3'd0, 64'h0);
          end else begin
            cur = nx;
          end
          sel = cur.sel; trans = cur.tr; addr = cur.a; write = cur.wr; size = cur.sz;
        end
      end
      repeat (10) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 1; i < 16; i++) cfg[i*64 +: 64] = {$urandom, $urandom};
    cfg[63:0] = 64'h8000_0000_0014_112D;
    #1;
    check("pin_merge_byte", 0, m_merge(64'h0, 64'h0000_0000_00A5_0000, 8'h7A, 3'd0),
          64'h0000_0000_00A5_0000);
    check("pin_merge_half", 0, m_merge(64'h1111_1111_1111_1111, 64'hFFFF_FFFF_FFFF_FFFF, 8'h7C, 3'd1),
          64'h1111_FFFF_1111_1111);
    check("pin_lookup_w0", 0, m_lookup(8'h00, 64'h0), 64'h8000_0000_0014_112D);
    check("pin_lookup_oor", 0, m_lookup(8'h80, 64'h1234), 64'h0);
    for (int c = 0; c < 20000; c++) begin
      if (g_inst[0].done && g_inst[1].done) break;
      @(posedge clk);
    end
    if (!(g_inst[0].done && g_inst[1].done)) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: drivers did not finish, got %0b%0b, want 11",
               g_inst[1].done, g_inst[0].done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
